// File: rtl/register_dump_reader.sv
// register_dump_reader: walks every register of the bank through a debug read port and
// streams each word LSB-first as bytes. Define DUMP_CHECKSUM_EN to append an XOR checksum byte.
module register_dump_reader #(
  parameter int SIZE          = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int SIZE_REG_DIR  = $clog2(NUM_REGISTERS),
  parameter int READ_LATENCY  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [SIZE_REG_DIR-1:0] o_reg_dir,
  input  logic [SIZE-1:0]         i_reg_data,
  output logic [7:0]              o_byte,
  output logic                    o_byte_valid,
  input  logic                    i_byte_ready
);

  localparam int BYTES = SIZE / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [SIZE_REG_DIR-1:0] LAST_DIR  = SIZE_REG_DIR'(NUM_REGISTERS - 1);
  localparam logic [BCW-1:0]          LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [WCW-1:0]          LAST_WAIT = WCW'(READ_LATENCY - 1);

  // Handshake: a byte moves when o_byte_valid and i_byte_ready are both high at posedge;
  // while valid is high and ready low, o_byte and o_byte_valid hold their values.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    SEND   = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    CHKSUM = 3'd3,
`endif
    DONE   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WCW-1:0]  wait_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [SIZE-1:0] shift;
  logic            accept;
  logic            read_done;
  logic            last_byte;
  logic            last_reg;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]      chksum;
`endif

  assign accept    = o_byte_valid & i_byte_ready;
  assign read_done = (wait_cnt == LAST_WAIT);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_reg  = (o_reg_dir == LAST_DIR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) state_next = READ;
      end
      READ: begin
        if (read_done) state_next = SEND;
      end
      SEND: begin
        if (accept && last_byte) begin
          if (!last_reg) begin
            state_next = READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_next = CHKSUM;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CHKSUM: begin
        if (accept) state_next = DONE;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy       = (state != IDLE);
    o_done       = (state == DONE);
    o_byte_valid = 1'b0;
    o_byte       = 8'h00;
    case (state)
      SEND: begin
        o_byte_valid = 1'b1;
        o_byte       = shift[7:0];
      end
`ifdef DUMP_CHECKSUM_EN
      CHKSUM: begin
        o_byte_valid = 1'b1;
        o_byte       = chksum;
      end
`endif
      default: begin
        o_byte_valid = 1'b0;
        o_byte       = 8'h00;
      end
    endcase
  end

  // Address, wait counter, byte counter and shift register advance only with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_dir <= '0;
      wait_cnt  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_reg_dir <= '0;
          wait_cnt  <= '0;
          byte_cnt  <= '0;
        end
        READ: begin
          if (read_done) begin
            shift    <= i_reg_data;
            byte_cnt <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        SEND: begin
          if (accept) begin
            shift    <= shift >> 8;
            byte_cnt <= byte_cnt + BCW'(1);
            if (last_byte && !last_reg) begin
              o_reg_dir <= o_reg_dir + SIZE_REG_DIR'(1);
              wait_cnt  <= '0;
            end
          end
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // XOR of every accepted data byte; the checksum byte itself is not folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      chksum <= 8'h00;
    end else if (state == IDLE) begin
      chksum <= 8'h00;
    end else if (state == SEND && accept) begin
      chksum <= chksum ^ shift[7:0];
    end
  end
`endif

endmodule
